// File: rtl/bp_fe_scan_sequencer.sv
// Frontend scan sequencer: turns 4-byte fetch words into 16/32-bit instructions for the scanner.
// Define BP_FE_SCAN_SEQ_COMPRESSED_EN for RVC halfword sequencing; otherwise each word passes through whole.
module bp_fe_scan_sequencer #(
    parameter int vaddr_width_p  = 39,
    parameter int instr_width_gp = 32
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      redirect_v_i,
    input  logic                      fetch_v_i,
    input  logic [vaddr_width_p-1:0]  fetch_pc_i,
    input  logic [instr_width_gp-1:0] fetch_data_i,
    output logic                      fetch_ready_o,
    output logic                      instr_v_o,
    output logic [instr_width_gp-1:0] instr_o,
    output logic [vaddr_width_p-1:0]  instr_pc_o,
    output logic                      instr_compressed_o,
    input  logic                      instr_ready_i,
    output logic                      misalign_o
);
    typedef enum logic [2:0] {S_EMPTY, S_LOW, S_HIGH, S_SPLIT, S_JOIN} state_e;

    state_e                    state_q, state_d, load_state;
    logic [vaddr_width_p-1:0]  base_q, base_d, load_base;
    logic [instr_width_gp-1:0] data_q, data_d;
    logic                      can_accept, retire, accept;

`ifdef BP_FE_SCAN_SEQ_COMPRESSED_EN
    logic [15:0]              half0, half1, split_half_q, split_half_d;
    logic [vaddr_width_p-1:0] split_pc_q, split_pc_d;
    logic [vaddr_width_p-3:0] split_word_next;
    logic                     half0_c, half1_c, split_match, fire;
    logic                     misalign_q, misalign_d;

    assign half0   = data_q[15:0];
    assign half1   = data_q[31:16];
    assign half0_c = (half0[1:0] != 2'b11);
    assign half1_c = (half1[1:0] != 2'b11);

    // split_pc always sits at offset 2, so the following word index is just the upper bits plus one.
    assign split_word_next = split_pc_q[vaddr_width_p-1:2] + (vaddr_width_p-2)'(1);
    assign split_match     = ~fetch_pc_i[1] && (fetch_pc_i[vaddr_width_p-1:2] == split_word_next);
    assign load_base       = fetch_pc_i & ~vaddr_width_p'(3);
    assign load_state      = fetch_pc_i[1] ? S_HIGH : S_LOW;
    assign misalign_o      = misalign_q;
`else
    assign load_base       = fetch_pc_i;
    assign load_state      = S_LOW;
    assign misalign_o      = 1'b0;
`endif

    always_comb begin
        state_d            = state_q;
        base_d             = base_q;
        data_d             = data_q;
        instr_v_o          = 1'b0;
        instr_o            = data_q;
        instr_pc_o         = base_q;
        instr_compressed_o = 1'b0;
        can_accept         = 1'b0;
        retire             = 1'b0;
`ifdef BP_FE_SCAN_SEQ_COMPRESSED_EN
        split_half_d       = split_half_q;
        split_pc_d         = split_pc_q;
        misalign_d         = 1'b0;
`endif

        case (state_q)
            S_EMPTY: can_accept = 1'b1;
            S_LOW: begin
                instr_v_o = 1'b1;
`ifdef BP_FE_SCAN_SEQ_COMPRESSED_EN
                if (half0_c) begin
                    instr_o            = {16'b0, half0};
                    instr_compressed_o = 1'b1;
                end else begin
                    retire = instr_ready_i;
                end
`else
                retire = instr_ready_i;
`endif
            end
`ifdef BP_FE_SCAN_SEQ_COMPRESSED_EN
            S_HIGH: begin
                if (half1_c) begin
                    instr_v_o          = 1'b1;
                    instr_o            = {16'b0, half1};
                    instr_pc_o         = base_q + vaddr_width_p'(2);
                    instr_compressed_o = 1'b1;
                    retire             = instr_ready_i;
                end
            end
            S_SPLIT: can_accept = 1'b1;
            S_JOIN: begin
                instr_v_o  = 1'b1;
                instr_o    = {half0, split_half_q};
                instr_pc_o = split_pc_q;
            end
`endif
            default: ;
        endcase

        if (redirect_v_i) begin
            instr_v_o  = 1'b0;
            can_accept = 1'b0;
            retire     = 1'b0;
        end
        // Retiring the last instruction frees the word buffer in the same cycle.
        fetch_ready_o = ~reset_i & (can_accept | retire);
        accept        = fetch_v_i & fetch_ready_o;
        if (accept) begin
            base_d = load_base;
            data_d = fetch_data_i;
        end

`ifdef BP_FE_SCAN_SEQ_COMPRESSED_EN
        fire = instr_v_o & instr_ready_i;
`endif
        if (redirect_v_i) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: if (accept) state_d = load_state;
                S_LOW: begin
`ifdef BP_FE_SCAN_SEQ_COMPRESSED_EN
                    if (fire) state_d = S_HIGH;
`endif
                    if (retire) state_d = accept ? load_state : S_EMPTY;
                end
`ifdef BP_FE_SCAN_SEQ_COMPRESSED_EN
                S_HIGH: begin
                    if (retire) begin
                        state_d = accept ? load_state : S_EMPTY;
                    end else if (!half1_c) begin
                        split_half_d = half1;
                        split_pc_d   = base_q + vaddr_width_p'(2);
                        state_d      = S_SPLIT;
                    end
                end
                S_SPLIT: begin
                    if (accept) begin
                        if (split_match) begin
                            state_d = S_JOIN;
                        end else begin
                            state_d    = load_state;
                            misalign_d = 1'b1;
                        end
                    end
                end
                S_JOIN: if (fire) state_d = S_HIGH;
`endif
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_EMPTY;
            base_q       <= '0;
            data_q       <= '0;
`ifdef BP_FE_SCAN_SEQ_COMPRESSED_EN
            split_half_q <= '0;
            split_pc_q   <= '0;
            misalign_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            data_q       <= data_d;
`ifdef BP_FE_SCAN_SEQ_COMPRESSED_EN
            split_half_q <= split_half_d;
            split_pc_q   <= split_pc_d;
            misalign_q   <= misalign_d;
`endif
        end
    end
endmodule

// File: tb/tb_bp_fe_scan_sequencer.sv
// Bench for bp_fe_scan_sequencer: directed vector table, async reset corner, then random traffic vs. a stream model.
module tb_bp_fe_scan_sequencer;
    localparam int W = 39;
`ifdef BP_FE_SCAN_SEQ_COMPRESSED_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_i, redirect_v_i, fetch_v_i, instr_ready_i;
    logic [W-1:0]  fetch_pc_i;
    logic [31:0]   fetch_data_i;
    logic          fetch_ready_o, instr_v_o, instr_compressed_o, misalign_o;
    logic [31:0]   instr_o;
    logic [W-1:0]  instr_pc_o;

    always #5 clk = ~clk;

    bp_fe_scan_sequencer #(.vaddr_width_p(W)) dut (
        .clk_i(clk), .reset_i(reset_i), .redirect_v_i(redirect_v_i),
        .fetch_v_i(fetch_v_i), .fetch_pc_i(fetch_pc_i), .fetch_data_i(fetch_data_i),
        .fetch_ready_o(fetch_ready_o), .instr_v_o(instr_v_o), .instr_o(instr_o),
        .instr_pc_o(instr_pc_o), .instr_compressed_o(instr_compressed_o),
        .instr_ready_i(instr_ready_i), .misalign_o(misalign_o)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rd, input logic fv, input logic [W-1:0] pc,
                         input logic [31:0] d, input logic rdy);
        redirect_v_i  = rd;
        fetch_v_i     = fv;
        fetch_pc_i    = pc;
        fetch_data_i  = d;
        instr_ready_i = rdy;
    endtask

    typedef struct {
        logic rd, fv; logic [W-1:0] pc; logic [31:0] data; logic irdy;
        logic ev; logic [31:0] ei; logic [W-1:0] epc; logic ec, er, em;
    } vec_t;
    vec_t vt[$];

    task automatic add(input logic rd, input logic fv, input logic [W-1:0] pc, input logic [31:0] d,
                       input logic irdy, input logic ev, input logic [31:0] ei, input logic [W-1:0] epc,
                       input logic ec, input logic er, input logic em);
        vec_t v;
        v.rd = rd; v.fv = fv; v.pc = pc; v.data = d; v.irdy = irdy;
        v.ev = ev; v.ei = ei; v.epc = epc; v.ec = ec; v.er = er; v.em = em;
        vt.push_back(v);
    endtask

    // Expected instruction stream built from accepted words by parsing halfwords.
    typedef struct { logic [31:0] instr; logic [W-1:0] pc; logic comp; } exp_t;
    exp_t         q[$];
    bit           tail, split_v;
    logic [15:0]  tail_half, split_half;
    logic [W-1:0] tail_pc, split_pc;

    function automatic bit is_c(input logic [15:0] h);
        return h[1:0] != 2'b11;
    endfunction

    task automatic push(input logic [31:0] i, input logic [W-1:0] p, input logic c);
        exp_t e;
        e.instr = i; e.pc = p; e.comp = c;
        q.push_back(e);
    endtask

    task automatic model_accept(input logic [W-1:0] pc, input logic [31:0] d, output bit mis);
        logic [W-1:0] wb, want;
        bit at_hi;
        mis = 1'b0;
        if (!CMP) begin
            push(d, pc, 1'b0);
            return;
        end
        wb = pc; wb[1:0] = 2'b00;
        at_hi = pc[1];
        if (split_v) begin
            want = split_pc + W'(2);
            if (!pc[1] && pc[W-1:2] == want[W-1:2]) begin
                push({d[15:0], split_half}, split_pc, 1'b0);
                at_hi = 1'b1;
            end else begin
                mis = 1'b1;
            end
            split_v = 1'b0;
        end
        if (!at_hi) begin
            if (is_c(d[15:0])) begin
                push({16'h0, d[15:0]}, wb, 1'b1);
                at_hi = 1'b1;
            end else begin
                push(d, wb, 1'b0);
            end
        end
        if (at_hi) begin
            if (is_c(d[31:16])) push({16'h0, d[31:16]}, wb + W'(2), 1'b1);
            else begin
                tail = 1'b1; tail_half = d[31:16]; tail_pc = wb + W'(2);
            end
        end
    endtask

    initial begin
        logic [W-1:0] npc, pc, maxa, wb;
        logic [63:0]  r64;
        logic [31:0]  d;
        logic         rd, fv, irdy, fire, accept, exp_r, exp_mis;
        bit           bub, nmis;
        int           r;

        reset_i = 1'b1;
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.instr_v", 64'(instr_v_o), 64'(0));
        chk("rst.fetch_ready", 64'(fetch_ready_o), 64'(0));
        chk("rst.misalign", 64'(misalign_o), 64'(0));
        @(posedge clk); #1 reset_i = 1'b0;
        @(negedge clk);
        chk("post_rst.fetch_ready", 64'(fetch_ready_o), 64'(1));
        chk("post_rst.instr_v", 64'(instr_v_o), 64'(0));
        @(posedge clk); #1;

`ifdef BP_FE_SCAN_SEQ_COMPRESSED_EN
        add(0, 1, 'h1000, 'h00A50513, 1,  0, 0, 0, 0, 1, 0);
        add(0, 1, 'h1004, 'h41114505, 1,  1, 'h00A50513, 'h1000, 0, 1, 0);
        add(0, 1, 'h1008, 'h00974501, 1,  1, 'h00004505, 'h1004, 1, 0, 0);
        add(0, 1, 'h1008, 'h00974501, 1,  1, 'h00004111, 'h1006, 1, 1, 0);
        add(0, 0, 0, 0, 1,                1, 'h00004501, 'h1008, 1, 0, 0);
        add(0, 1, 'h100C, 'h4505FFFF, 1,  0, 0, 0, 0, 0, 0);
        add(0, 1, 'h100C, 'h4505FFFF, 1,  0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 1,                1, 'hFFFF0097, 'h100A, 0, 0, 0);
        add(0, 1, 'h2002, 'h00970000, 1,  1, 'h00004505, 'h100E, 1, 1, 0);
        add(0, 0, 0, 0, 1,                0, 0, 0, 0, 0, 0);
        add(0, 1, 'h3000, 'h00A50513, 1,  0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0,                1, 'h00A50513, 'h3000, 0, 0, 1);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 1, 'h00A50513, 'h3000, 0, 0, 0);
        add(0, 1, 'h4002, 'h00970000, 1,  1, 'h00A50513, 'h3000, 0, 1, 0);
        add(0, 0, 0, 0, 1,                0, 0, 0, 0, 0, 0);
        add(0, 1, 'h4004, 'h12345678, 1,  0, 0, 0, 0, 1, 0);
        add(1, 1, 'h5000, 'h00000000, 1,  0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1,                0, 0, 0, 0, 1, 0);
`else
        add(0, 1, 'h1000, 'h00A50513, 1,  0, 0, 0, 0, 1, 0);
        add(0, 1, 'h1006, 'h41114505, 1,  1, 'h00A50513, 'h1000, 0, 1, 0);
        add(0, 1, 'h2000, 'h00974501, 0,  1, 'h41114505, 'h1006, 0, 0, 0);
        add(0, 1, 'h2000, 'h00974501, 0,  1, 'h41114505, 'h1006, 0, 0, 0);
        add(0, 1, 'h2000, 'h00974501, 1,  1, 'h41114505, 'h1006, 0, 1, 0);
        add(0, 0, 0, 0, 1,                1, 'h00974501, 'h2000, 0, 1, 0);
        add(1, 0, 0, 0, 1,                0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1,                0, 0, 0, 0, 1, 0);
`endif
        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].rd, vt[i].fv, vt[i].pc, vt[i].data, vt[i].irdy);
            @(negedge clk);
            chk($sformatf("vec%0d.instr_v", i), 64'(instr_v_o), 64'(vt[i].ev));
            if (vt[i].ev) begin
                chk($sformatf("vec%0d.instr", i), 64'(instr_o), 64'(vt[i].ei));
                chk($sformatf("vec%0d.pc", i), 64'(instr_pc_o), 64'(vt[i].epc));
                chk($sformatf("vec%0d.compressed", i), 64'(instr_compressed_o), 64'(vt[i].ec));
            end
            chk($sformatf("vec%0d.fetch_ready", i), 64'(fetch_ready_o), 64'(vt[i].er));
            chk($sformatf("vec%0d.misalign", i), 64'(misalign_o), 64'(vt[i].em));
            @(posedge clk); #1;
        end

`ifdef BP_FE_SCAN_SEQ_COMPRESSED_EN
        drive(1'b0, 1'b1, W'('h5002), 32'h00970000, 1'b1); @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, '0, 1'b0);                   @(posedge clk); #1;
        drive(1'b0, 1'b1, W'('h5004), 32'h00001111, 1'b0); @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        chk("join.instr_v", 64'(instr_v_o), 64'(1));
        chk("join.instr", 64'(instr_o), 64'h11110097);
        chk("join.pc", 64'(instr_pc_o), 64'h5002);
        chk("join.fetch_ready", 64'(fetch_ready_o), 64'(0));
`else
        drive(1'b0, 1'b1, W'('h5000), 32'hCAFE0013, 1'b0); @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        chk("low.instr_v", 64'(instr_v_o), 64'(1));
        chk("low.instr", 64'(instr_o), 64'hCAFE0013);
`endif
        #1 reset_i = 1'b1;
        #1;
        chk("rst_mid.instr_v", 64'(instr_v_o), 64'(0));
        chk("rst_mid.fetch_ready", 64'(fetch_ready_o), 64'(0));
        @(posedge clk); #1 reset_i = 1'b0;
        @(negedge clk);
        chk("rst_mid.fetch_ready_after", 64'(fetch_ready_o), 64'(1));
        chk("rst_mid.instr_v_after", 64'(instr_v_o), 64'(0));
        @(posedge clk); #1;

        q.delete(); tail = 0; split_v = 0; exp_mis = 1'b0;
        npc  = W'('h1000);
        maxa = '1; maxa[1:0] = 2'b00;
        for (int n = 0; n < 3000; n++) begin
            rd   = ($urandom_range(0, 19) == 0);
            fv   = ($urandom_range(0, 3) != 0);
            irdy = ($urandom_range(0, 3) != 0);
            r    = $urandom_range(0, 15);
            if (r == 0) begin
                r64 = {$urandom, $urandom};
                pc = r64[W-1:0]; pc[0] = 1'b0;
            end else if (r == 1) begin
                pc = maxa; pc[1] = 1'($urandom_range(0, 1));
            end else begin
                pc = npc;
            end
            d = $urandom;
            if ($urandom_range(0, 2) == 0) d[17:16] = 2'b11;
            if ($urandom_range(0, 3) == 0) d[1:0] = 2'b11;
            drive(rd, fv, pc, d, irdy);
            @(negedge clk);

            bub = (q.size() == 0) && tail;
            chk($sformatf("rnd%0d.instr_v", n), 64'(instr_v_o), 64'(!rd && q.size() != 0));
            if (instr_v_o && q.size() != 0) begin
                chk($sformatf("rnd%0d.instr", n), 64'(instr_o), 64'(q[0].instr));
                chk($sformatf("rnd%0d.pc", n), 64'(instr_pc_o), 64'(q[0].pc));
                chk($sformatf("rnd%0d.compressed", n), 64'(instr_compressed_o), 64'(q[0].comp));
            end
            fire  = instr_v_o & irdy;
            exp_r = rd ? 1'b0 : (q.size() == 0) ? !tail : (fire && q.size() == 1 && !tail);
            chk($sformatf("rnd%0d.fetch_ready", n), 64'(fetch_ready_o), 64'(exp_r));
            chk($sformatf("rnd%0d.misalign", n), 64'(misalign_o), 64'(exp_mis));
            accept = fv & fetch_ready_o;

            nmis = 1'b0;
            if (rd) begin
                q.delete(); tail = 0; split_v = 0;
            end else begin
                if (fire && q.size() != 0) void'(q.pop_front());
                if (bub) begin
                    tail = 0; split_v = 1; split_half = tail_half; split_pc = tail_pc;
                end
                if (accept) begin
                    model_accept(pc, d, nmis);
                    wb = pc; wb[1:0] = 2'b00;
                    npc = wb + W'(4);
                end
            end
            exp_mis = nmis;
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
